// File: rtl/paddle_pkg.sv
// Shared constants and types for the paddle pulse generator.
package paddle_pkg;

  // Default paddle travel limits and the position after reset
  localparam int DEF_POS_MIN      = 8;
  localparam int DEF_POS_MAX      = 217;
  localparam int DEF_POS_INIT     = 112;
  localparam int DEF_ACCEL_FRAMES = 8;
  localparam int DEF_SYNC_STAGES  = 2;

  // Largest per-frame step; the step doubles 1 -> 2 -> 4 and stays there
  localparam int STEP_MAX = 4;

  // FSM state encoding
  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  typedef enum logic [1:0] {
    S_WAIT = ST_WAIT,
    S_LOW  = ST_LOW,
    S_HIGH = ST_HIGH
  } state_e;

  // Direction requested by the buttons in a frame
  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2
  } dir_e;

  // Next step size after a full hold period, saturating at STEP_MAX
  function automatic logic [2:0] step_double(input logic [2:0] s);
    if (s >= 3'(STEP_MAX)) return 3'(STEP_MAX);
    return {s[1:0], 1'b0};
  endfunction

endpackage

// File: rtl/paddle_pulse_gen_if.sv
// Video timing in, buttons in, paddle comparator emulation out.
interface paddle_pulse_gen_if;
  logic        btn_left;
  logic        btn_right;
  logic        hsync;
  logic        vsync;
  logic [15:0] vpos;
  logic        hpaddle;
  logic [8:0]  paddle_target;

  // Side that drives buttons and video timing (board / bench)
  modport master (
    output btn_left, btn_right, hsync, vsync, vpos,
    input  hpaddle, paddle_target
  );

  // The paddle pulse generator itself
  modport slave (
    input  btn_left, btn_right, hsync, vsync, vpos,
    output hpaddle, paddle_target
  );
endinterface

// File: rtl/paddle_btn_sync.sv
// Multi-flop synchronizer for the two raw push-button inputs.
module paddle_btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_raw,
  output logic [1:0] btn_sync
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] sync_d;

      // Shift the raw level in at bit 0; the oldest sample leaves at the top
      always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw[gi]};
      end

      // Synchronizer chain register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
      end

      assign btn_sync[gi] = sync_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/paddle_pulse_gen.sv
// Digital paddle: buttons move a per-frame target line, and hpaddle goes
// high once the beam has passed that line, so a receiver latching vpos on
// hsync while hpaddle is low captures exactly the target.
module paddle_pulse_gen
  import paddle_pkg::*;
#(
  parameter int POS_MIN      = DEF_POS_MIN,
  parameter int POS_MAX      = DEF_POS_MAX,
  parameter int POS_INIT     = DEF_POS_INIT,
  parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               reset,
  paddle_pulse_gen_if.slave  bus
);

  localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic signed [9:0] MIN_S = 10'(POS_MIN);
  localparam logic signed [9:0] MAX_S = 10'(POS_MAX);

  // Synchronized buttons
  logic [1:0] btn_s;

  paddle_btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  ({bus.btn_left, bus.btn_right}),
    .btn_sync (btn_s)
  );

  logic btn_left_s, btn_right_s;
  assign btn_left_s  = btn_s[1];
  assign btn_right_s = btn_s[0];

  // Sync edge detect
  logic hs_q, hs_d, vs_q, vs_d;
  logic hs_rise, vs_rise;

  assign hs_rise = bus.hsync & ~hs_q;
  assign vs_rise = bus.vsync & ~vs_q;

  // Previous-cycle copy of hsync/vsync for rising-edge detection
  always_comb begin
    hs_d = bus.hsync;
    vs_d = bus.vsync;
  end

  // Edge-detect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  // Target / acceleration datapath
  logic [8:0]        target_q, target_d;
  logic [2:0]        step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  dir_e              dir_q, dir_d;
  dir_e              cur_dir;
  logic [2:0]        step_use;
  logic [HOLD_W-1:0] hold_use;
  logic signed [9:0] base, delta, sum;

  // Frame-rate target update, evaluated only on the vsync rising edge
  always_comb begin
    target_d = target_q;
    step_d   = step_q;
    hold_d   = hold_q;
    dir_d    = dir_q;
    step_use = step_q;
    hold_use = hold_q;
    base     = $signed({1'b0, target_q});
    delta    = $signed({7'd0, step_q});
    sum      = base;

    if (btn_right_s && !btn_left_s)      cur_dir = DIR_RIGHT;
    else if (btn_left_s && !btn_right_s) cur_dir = DIR_LEFT;
    else                                 cur_dir = DIR_NONE;

    if (vs_rise) begin
      if (cur_dir == DIR_NONE) begin
        step_d = 3'd1;
        hold_d = '0;
        dir_d  = DIR_NONE;
      end else begin
        // A fresh press or a reversal starts again at the slowest speed
        if (cur_dir != dir_q) begin
          step_use = 3'd1;
          hold_use = '0;
        end
        dir_d = cur_dir;
        delta = $signed({7'd0, step_use});
        sum   = (cur_dir == DIR_RIGHT) ? (base + delta) : (base - delta);

        if (hold_use == HOLD_W'(ACCEL_FRAMES - 1)) begin
          hold_d = '0;
          step_d = step_double(step_use);
        end else begin
          hold_d = hold_use + HOLD_W'(1);
          step_d = step_use;
        end

        // Hitting a wall kills the accumulated speed
        if (sum < MIN_S) begin
          target_d = 9'(POS_MIN);
          step_d   = 3'd1;
          hold_d   = '0;
        end else if (sum > MAX_S) begin
          target_d = 9'(POS_MAX);
          step_d   = 3'd1;
          hold_d   = '0;
        end else begin
          target_d = sum[8:0];
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= 9'(POS_INIT);
      step_q   <= 3'd1;
      hold_q   <= '0;
      dir_q    <= DIR_NONE;
    end else begin
      target_q <= target_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      dir_q    <= dir_d;
    end
  end

  // Comparator FSM
  state_e state_q, state_d;
  logic   hpaddle_q, hpaddle_d;

  // Next state; vsync wins over hsync so a new frame always starts low
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: if (vs_rise) state_d = S_LOW;
      S_LOW: begin
        if (vs_rise)
          state_d = S_LOW;
        else if (hs_rise && (bus.vpos[8:0] >= target_q))
          state_d = S_HIGH;
      end
      S_HIGH: if (vs_rise) state_d = S_LOW;
      default: state_d = S_WAIT;
    endcase
    hpaddle_d = (state_d == S_HIGH);
  end

  // State and registered hpaddle, one cycle behind the triggering edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT;
      hpaddle_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hpaddle_q <= hpaddle_d;
    end
  end

  assign bus.hpaddle       = hpaddle_q;
  assign bus.paddle_target = target_q;

endmodule

// File: tb/tb_paddle_pulse_gen.sv
// Bench for paddle_pulse_gen: frame-level stimulus with a receiver model.
module tb_paddle_pulse_gen;
  import paddle_pkg::*;

  localparam int V_LINES = 240;

  logic clk = 1'b0;
  logic reset;

  paddle_pulse_gen_if bus ();

  paddle_pulse_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int frame_no = 0;
  int exp_q[$];

  // Receiver: latch vpos on hsync while hpaddle is still low; clear on vsync
  logic [8:0] rx_pos;
  always @(posedge bus.hsync or posedge bus.vsync) begin
    if (bus.vsync)         rx_pos = 9'h1FF;
    else if (!bus.hpaddle) rx_pos = bus.vpos[8:0];
  end

  // Behavioural model of the target/step state
  int m_target, m_step, m_hold, m_dir;

  task automatic model_reset();
    m_target = 112; m_step = 1; m_hold = 0; m_dir = 0;
  endtask

  task automatic model_frame(input bit l, input bit r);
    int d, nxt;
    if (l == r) begin
      m_step = 1; m_hold = 0; m_dir = 0;
    end else begin
      d = r ? 1 : -1;
      if (d != m_dir) begin m_step = 1; m_hold = 0; m_dir = d; end
      nxt = m_target + d * m_step;
      if (m_hold == 7) begin
        m_hold = 0;
        m_step = (m_step >= 4) ? 4 : m_step * 2;
      end else begin
        m_hold = m_hold + 1;
      end
      if (nxt < 8)   begin nxt = 8;   m_step = 1; m_hold = 0; end
      if (nxt > 217) begin nxt = 217; m_step = 1; m_hold = 0; end
      m_target = nxt;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("hpaddle in reset", int'(bus.hpaddle), 0);
    check("target in reset", int'(bus.paddle_target), 112);
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Start a frame: one vsync pulse, then compare target/step from the scoreboard
  task automatic vsync_pulse(input int exp_tgt, input int exp_step, input string tag);
    int e;
    exp_q.push_back(exp_tgt);
    @(negedge clk);
    bus.vsync = 1'b1; bus.hsync = 1'b0; bus.vpos = 16'(V_LINES);
    @(negedge clk);
    e = exp_q.pop_front();
    check({tag, " target"}, int'(bus.paddle_target), e);
    check({tag, " step"}, int'(dut.step_q), exp_step);
    check({tag, " hpaddle after vsync"}, int'(bus.hpaddle), 0);
    @(negedge clk);
    bus.vsync = 1'b0;
    frame_no++;
    $display("frame %0d %s: target %0d step %0d", frame_no, tag, int'(bus.paddle_target), int'(dut.step_q));
  endtask

  // Scan lines; hpaddle must follow the beam crossing the target line
  task automatic run_lines(input int first, input int last, input int tgt, input bit stay_low);
    for (int v = first; v <= last; v++) begin
      @(negedge clk);
      bus.vpos = 16'(v); bus.hsync = 1'b0;
      @(negedge clk);
      bus.hsync = 1'b1;
      check("hpaddle before hs edge", int'(bus.hpaddle), (!stay_low && v > tgt) ? 1 : 0);
      @(negedge clk);
      bus.hsync = 1'b0;
      check("hpaddle after hs edge", int'(bus.hpaddle), (!stay_low && v >= tgt) ? 1 : 0);
      @(negedge clk);
    end
  endtask

  task automatic frame(input bit l, input bit r, input bit full,
                       input int exp_tgt, input int exp_step, input string tag);
    @(negedge clk);
    bus.btn_left = l; bus.btn_right = r;
    repeat (3) @(negedge clk);
    vsync_pulse(exp_tgt, exp_step, tag);
    if (full) begin
      run_lines(0, V_LINES - 1, exp_tgt, 1'b0);
      check({tag, " receiver capture"}, int'(rx_pos), exp_tgt);
    end
  endtask

  typedef struct {
    bit    rst;
    bit    l;
    bit    r;
    bit    full;
    int    tgt;
    int    step;
    string tag;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s;
    // Table: idle frames, right from reset, then left acceleration from reset
    for (int i = 0; i < 3; i++) tbl.push_back('{0, 0, 0, 1, 112, 1, "t1 idle"});
    tbl.push_back('{0, 0, 1, 1, 113, 1, "t2 right"});
    tbl.push_back('{0, 0, 1, 1, 114, 1, "t2 right"});
    tbl.push_back('{0, 0, 1, 1, 115, 1, "t2 right"});
    t = 112;
    for (int i = 0; i < 20; i++) begin
      t = t - ((i < 8) ? 1 : (i < 16) ? 2 : 4);
      s = (i >= 15) ? 4 : (i >= 7) ? 2 : 1;
      tbl.push_back('{(i == 0), 1, 0, (i == 19), t, s, "t3 left accel"});
    end

    reset = 1'b0;
    bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.hsync = 1'b0; bus.vsync = 1'b0; bus.vpos = '0;
    model_reset();
    apply_reset(3);

    foreach (tbl[k]) begin
      if (tbl[k].rst) apply_reset(2);
      model_frame(tbl[k].l, tbl[k].r);
      frame(tbl[k].l, tbl[k].r, tbl[k].full, tbl[k].tgt, tbl[k].step, tbl[k].tag);
    end
    check("t3 final target 72", int'(bus.paddle_target), 72);

    // Right until clamped at 217, holding past the wall
    for (int k = 0; k < 50; k++) begin
      model_frame(0, 1);
      frame(0, 1, (k == 49), m_target, m_step, "t4 right clamp");
    end
    check("t4 clamp max", int'(bus.paddle_target), 217);

    // Left until clamped at 8
    for (int k = 0; k < 70; k++) begin
      model_frame(1, 0);
      frame(1, 0, (k == 69), m_target, m_step, "t4 left clamp");
    end
    check("t4 clamp min", int'(bus.paddle_target), 8);

    // Walk to 150: reset to 112, right 19 frames, release, right 2 frames
    apply_reset(2);
    for (int k = 0; k < 19; k++) begin model_frame(0, 1); frame(0, 1, 0, m_target, m_step, "t5 approach"); end
    model_frame(0, 0); frame(0, 0, 0, m_target, m_step, "t5 release");
    for (int k = 0; k < 2; k++) begin model_frame(0, 1); frame(0, 1, 0, m_target, m_step, "t5 approach"); end
    check("t5 start 150", int'(bus.paddle_target), 150);
    for (int k = 0; k < 5; k++) begin
      model_frame(1, 1);
      frame(1, 1, (k == 4), 150, 1, "t5 both");
    end
    // Hold must have been cleared: eight single steps before doubling
    for (int k = 0; k < 9; k++) begin model_frame(0, 1); frame(0, 1, 0, m_target, m_step, "t5 right after both"); end
    check("t5 after both", int'(bus.paddle_target), 160);

    // Reset for two cycles while hpaddle is high mid-frame
    model_frame(0, 0);
    @(negedge clk); bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    repeat (3) @(negedge clk);
    vsync_pulse(m_target, m_step, "t6 pre-reset");
    run_lines(0, 199, m_target, 1'b0);
    check("t6 high before reset", int'(bus.hpaddle), 1);
    apply_reset(2);
    run_lines(200, V_LINES - 1, 0, 1'b1);
    model_frame(0, 0);
    frame(0, 0, 1, 112, 1, "t6 post-reset");

    // vsync and hsync rising together: vsync wins, hpaddle stays low
    for (int k = 0; k < 2; k++) begin
      model_frame(0, 0);
      @(negedge clk);
      bus.vpos = 16'd300; bus.hsync = 1'b1; bus.vsync = 1'b1;
      @(negedge clk);
      check("vs over hs hpaddle", int'(bus.hpaddle), 0);
      check("vs over hs target", int'(bus.paddle_target), m_target);
      @(negedge clk);
      bus.hsync = 1'b0; bus.vsync = 1'b0;
      repeat (2) @(negedge clk);
      check("vs over hs hpaddle later", int'(bus.hpaddle), 0);
      $display("priority pulse %0d: hpaddle %0d", k, int'(bus.hpaddle));
    end
    // The frame after still behaves normally
    run_lines(0, 130, 112, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
